// File: rtl/sdram_seq_pkg.sv
// Shared types for the SDRAM command sequencer: FSM states, the packed command word
// and the data widths used on the controller and return-FIFO sides.
package sdram_seq_pkg;

  localparam int CMD_W     = 31;
  localparam int ADDR_W    = 21;
  localparam int DIN_W     = 8;
  localparam int SD_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    EXEC,
    RWAIT,
    PUSH
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DIN_W-1:0]  din;
    logic              aux;
    logic              write;
  } cmd_t;

endpackage

// File: rtl/sdram_seq_latency_cnt.sv
// Loadable down-counter used to time the controller's read latency.
// zero is high when the current decrement lands the count on zero.
module sdram_seq_latency_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign zero = (count_reg <= ONE);

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// Pops packed commands from the serial-command FIFO, runs each as one SDRAM controller slot
// and returns read words to the read-data FIFO. Optional stats counters: SDRAM_SEQ_STATS_EN.
module sdram_cmd_sequencer
  import sdram_seq_pkg::*;
#(
  parameter int READ_LAT  = 2,
  parameter int STALL_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sdram_ready,
  input  logic                 cmd_empty,
  input  logic [CMD_W-1:0]     cmd_q,
  output logic                 cmd_rd,
  output logic [ADDR_W-1:0]    sd_addr,
  output logic [DIN_W-1:0]     sd_din,
  output logic                 sd_aux,
  output logic                 sd_we,
  input  logic [SD_DATA_W-1:0] sd_dout,
  input  logic                 ret_full,
  output logic                 ret_wr,
  output logic [SD_DATA_W-1:0] ret_data,
  output logic                 busy,
  output logic                 err
`ifdef SDRAM_SEQ_STATS_EN
  ,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count
`endif
);

  localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);

  state_t     state_reg, state_next;
  cmd_t       cmd;
  logic       write_reg;
  logic [7:0] stall_reg;

  logic latch, capture, drop, stall_inc;
  logic lat_load, lat_dec, lat_zero;

  assign cmd  = cmd_t'(cmd_q);
  assign busy = (state_reg != IDLE);

  sdram_seq_latency_cnt #(
    .W (4)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  always_comb begin
    state_next = state_reg;
    cmd_rd     = 1'b0;
    sd_we      = 1'b0;
    ret_wr     = 1'b0;
    latch      = 1'b0;
    capture    = 1'b0;
    drop       = 1'b0;
    stall_inc  = 1'b0;
    lat_load   = 1'b0;
    lat_dec    = 1'b0;
    case (state_reg)
      IDLE: begin
        // rst gate keeps the strobe low while the async reset is held
        if (sdram_ready && !cmd_empty && !rst) begin
          cmd_rd     = 1'b1;
          state_next = POP;
        end
      end
      POP:   state_next = LATCH;
      LATCH: begin
        latch      = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        if (write_reg) begin
          sd_we      = 1'b1;
          state_next = IDLE;
        end else if (READ_LAT == 1) begin
          capture    = 1'b1;
          state_next = PUSH;
        end else begin
          lat_load   = 1'b1;
          state_next = RWAIT;
        end
      end
      RWAIT: begin
        lat_dec = 1'b1;
        if (lat_zero) begin
          capture    = 1'b1;
          state_next = PUSH;
        end
      end
      PUSH: begin
        if (!ret_full) begin
          ret_wr     = 1'b1;
          state_next = IDLE;
        end else if ((int'(stall_reg) + 1) >= STALL_MAX) begin
          drop       = 1'b1;
          state_next = IDLE;
        end else begin
          stall_inc  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      write_reg <= 1'b0;
      sd_addr   <= '0;
      sd_din    <= '0;
      sd_aux    <= 1'b0;
      ret_data  <= '0;
      stall_reg <= '0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch) begin
        sd_addr   <= cmd.addr;
        sd_din    <= cmd.din;
        sd_aux    <= cmd.aux;
        write_reg <= cmd.write;
      end
      if (capture) begin
        ret_data <= sd_dout;
      end
      // capture is the only way into PUSH, so it doubles as the stall-counter clear
      if (capture) begin
        stall_reg <= '0;
      end else if (stall_inc && (stall_reg != 8'hFF)) begin
        stall_reg <= stall_reg + 8'd1;
      end
      if (drop) begin
        err <= 1'b1;
      end
    end
  end

`ifdef SDRAM_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (sd_we) begin
        wr_count <= wr_count + 16'd1;
      end
      if (ret_wr) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/sdram_cmd_sequencer.md
# sdram_cmd_sequencer

Single-clock command sequencer in the slow memory domain (`clk2M`), between the serial-command FIFO output and the Apple2e SDRAM controller's CPU-side port, with a return path into the read-data FIFO. Each operation pops one packed command {addr, din, aux, write} and drives it onto the controller for exactly one memory slot. For reads, it waits a fixed latency, captures the 16-bit word and pushes it to the return FIFO. It replaces ad-hoc strobing with a defined FSM, back-pressure handling and a sticky error flag.

## Interface
Parameters:
- `READ_LAT`, default 2: clk cycles from the first EXEC cycle of a read to the cycle in which `sd_dout` is valid; range 1..15.
- `STALL_MAX`, default 255: maximum clk cycles a completed read may wait on a full return FIFO before it is dropped.

Ports (clock and reset first):
- `clk` in 1: memory-slot clock (clk2M).
- `rst` in 1: asynchronous, active-high reset.
- `sdram_ready` in 1: controller initialised; no command is popped while low.
- `cmd_empty` in 1: command FIFO empty.
- `cmd_q` in 31: {addr[20:0], din[7:0], aux, write}; valid the cycle after `cmd_rd`.
- `cmd_rd` out 1: command FIFO read strobe.
- `sd_addr` out 21: controller byte address.
- `sd_din` out 8: controller write data.
- `sd_aux` out 1: controller aux/bank select.
- `sd_we` out 1: controller write request, exactly one cycle per write.
- `sd_dout` in 16: controller read data.
- `ret_full` in 1: return FIFO full.
- `ret_wr` out 1: return FIFO write strobe.
- `ret_data` out 16: word pushed to the return FIFO.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky overflow/drop flag.

## Operation
FSM states: IDLE, POP, LATCH, EXEC, RWAIT, PUSH.
- IDLE: if `sdram_ready && !cmd_empty`, assert `cmd_rd` for 1 cycle → POP.
- POP: FIFO output settles → LATCH.
- LATCH: register `cmd_q` into `sd_addr`/`sd_din`/`sd_aux` and an internal write bit → EXEC.
- EXEC, write: `sd_we`=1 for this cycle only → IDLE.
- EXEC, read: load the latency counter with `READ_LAT-1` → RWAIT, or → PUSH directly if `READ_LAT`=1.
- RWAIT: decrement the counter; at 0, capture `sd_dout` into `ret_data` → PUSH.
- PUSH: if `!ret_full`, assert `ret_wr` for 1 cycle → IDLE.
- PUSH while full: increment the stall counter. When it reaches `STALL_MAX`, drop the word, set `err` → IDLE.
- `sd_addr`/`sd_din`/`sd_aux` hold their last values until the next LATCH.
- `sdram_ready` falling mid-operation: the current op completes; no new pop is issued.
- `cmd_empty` is sampled only in IDLE; `cmd_rd` never asserts while it is high.
- `err` clears only on `rst`.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Write: `cmd_rd` in cycle N, `sd_we` in cycle N+3; back in IDLE at N+4. Peak rate is 1 op per 4 cycles.
- Read: `cmd_rd` in cycle N, EXEC in cycle N+3.
  - `sd_dout` is sampled at N+2+`READ_LAT`.
  - `ret_wr` asserts at N+3+`READ_LAT` at the earliest.
- `rst` asserted at any point: outputs go to 0 immediately (async). A popped command in flight is lost and is not retried.
- Stall counter: 8 bits, saturating, cleared on entry to PUSH.
- Latency counter: 4 bits.

## Configuration
- `SDRAM_SEQ_STATS_EN` defined:
  - adds outputs `wr_count` and `rd_count`, each 16-bit and wrapping;
  - `wr_count` increments on `sd_we`, `rd_count` on `ret_wr`;
  - both reset to 0.
- `SDRAM_SEQ_STATS_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `sdram_seq_pkg` contains:
  - the state enum;
  - the packed struct `cmd_t` {addr[20:0], din[7:0], aux, write}, 31 bits, plus `CMD_W`=31;
  - `SD_DATA_W`=16.
- One sub-module, `sdram_seq_latency_cnt`: the loadable down-counter with a zero flag, reused for the read-latency wait.

## Test plan
- Write: `cmd_q`={0x01234, 0xA5, aux=0, write=1} → `sd_we` pulses once, 3 cycles after `cmd_rd`; `sd_addr`=0x01234, `sd_din`=0xA5.
- Read, `READ_LAT`=2: model returns 0xBEEF → `ret_wr` once with `ret_data`=0xBEEF, 5 cycles after `cmd_rd`.
- Back-pressure: `ret_full` held 10 cycles during PUSH → `ret_wr` on the cycle after release, `err`=0. With `ret_full` held 300 cycles → word dropped, `err`=1, FSM returns to IDLE.
- `sdram_ready`=0 with `cmd_empty`=0 → no `cmd_rd` for 100 cycles. On raising `sdram_ready` → `cmd_rd` on the next cycle.
- `rst` pulsed in RWAIT → all outputs 0 asynchronously, `busy`=0; no `ret_wr` afterwards.
- With `SDRAM_SEQ_STATS_EN`: 3 writes + 2 reads → `wr_count`=3, `rd_count`=2.
